pixel_collector: RTL and testbench

//   Downstream consumer of the watermark stage. Captures each modified pixel
//   (Pixel_Data qualified by new_pixel) and packs pixels LSB-first into

---
 rtl/pixel_collector.sv | 186 ++++++++++++++++++
 tb/tb_pixel_collector.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_collector.sv
// Packs watermarked pixels LSB-first into bus words, buffers them in a FIFO and
// drains them over valid/ready; a rising Image_Done closes the frame. Assumes PPW >= 2.
module pixel_collector #(
    parameter int Data_Depth = 8,
    parameter int Amba_Word  = 16,
    parameter int Fifo_Depth = 16,
    parameter int Cnt_Width  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  new_pixel,
    input  logic [Data_Depth-1:0] Pixel_Data,
    input  logic                  Image_Done,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [Amba_Word-1:0]  out_word,
    output logic                  out_last,
    output logic [Cnt_Width-1:0]  frame_count,
    output logic                  frame_done,
    output logic                  overflow
);
    localparam int PPW   = Amba_Word / Data_Depth;
    localparam int IDX_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int PTR_W = $clog2(Fifo_Depth);

    typedef enum logic {COLLECT, FLUSH} state_t;
    state_t state_reg, state_next;

    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [Amba_Word-1:0] pack_reg, pack_next, lane_word;
    logic [Cnt_Width-1:0] count_reg, count_next;
    logic                 words_reg, words_next;     // a word was pushed this frame
    logic                 tagged_reg, tagged_next;   // newest push already carries last
    logic                 pushed_ok_reg;
    logic                 done_d_reg;
    logic                 frame_done_reg, overflow_reg;
    logic [Cnt_Width-1:0] frame_count_reg;

    logic [Amba_Word-1:0] word_mem [Fifo_Depth];
    logic [Fifo_Depth-1:0] last_mem;
    logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg, newest_ptr;
    logic [PTR_W:0]       occ_reg;

    logic                 done_rise, push_req, push_last, push_ok, mark_last, close;
    logic                 pop, fifo_full, newest_live;
    logic [Amba_Word-1:0] push_word;

    genvar gi;
    generate
        for (gi = 0; gi < PPW; gi++) begin : g_lane
            assign lane_word[gi*Data_Depth +: Data_Depth] =
                (new_pixel && idx_reg == IDX_W'(gi)) ? Pixel_Data
                                                      : pack_reg[gi*Data_Depth +: Data_Depth];
        end
    endgenerate

    assign done_rise  = Image_Done && !done_d_reg;
    assign pop        = out_valid && out_ready;
    assign fifo_full  = occ_reg == (PTR_W+1)'(Fifo_Depth);
    assign push_ok    = push_req && (!fifo_full || pop);
    assign newest_ptr = wr_ptr_reg - PTR_W'(1);
    // The newest entry can only still be tagged if it survives this cycle's pop.
    assign newest_live = pushed_ok_reg &&
                         (occ_reg > (PTR_W+1)'(1) || (occ_reg == (PTR_W+1)'(1) && !pop));

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        pack_next   = pack_reg;
        count_next  = count_reg;
        words_next  = words_reg;
        tagged_next = tagged_reg;
        push_req    = 1'b0;
        push_word   = lane_word;
        push_last   = 1'b0;
        mark_last   = 1'b0;
        close       = 1'b0;
        case (state_reg)
            COLLECT: begin
                if (new_pixel) begin
                    count_next = count_reg + Cnt_Width'(1);
                    if (idx_reg == IDX_W'(PPW-1)) begin
                        push_req    = 1'b1;
                        push_last   = done_rise;
                        tagged_next = done_rise;
                        words_next  = 1'b1;
                        pack_next   = '0;
                        idx_next    = '0;
                    end else begin
                        pack_next = lane_word;
                        idx_next  = idx_reg + IDX_W'(1);
                    end
                end
                if (done_rise)
                    state_next = FLUSH;
            end
            FLUSH: begin
                state_next = COLLECT;
                if (idx_reg != '0) begin
                    push_req  = 1'b1;
                    push_word = pack_reg;
                    push_last = 1'b1;
                    close     = 1'b1;
                end else if (words_reg) begin
                    close = 1'b1;
                    if (!tagged_reg) begin
                        if (newest_live) begin
                            mark_last = 1'b1;
                        end else begin
                            push_req  = 1'b1;
                            push_word = '0;
                            push_last = 1'b1;
                        end
                    end
                end
                // A pixel arriving now opens the next frame.
                count_next  = new_pixel ? Cnt_Width'(1) : '0;
                idx_next    = new_pixel ? IDX_W'(1) : '0;
                pack_next   = new_pixel ? Amba_Word'(Pixel_Data) : '0;
                words_next  = 1'b0;
                tagged_next = 1'b0;
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= COLLECT;
            idx_reg         <= '0;
            pack_reg        <= '0;
            count_reg       <= '0;
            words_reg       <= 1'b0;
            tagged_reg      <= 1'b0;
            pushed_ok_reg   <= 1'b0;
            done_d_reg      <= 1'b0;
            frame_done_reg  <= 1'b0;
            frame_count_reg <= '0;
            overflow_reg    <= 1'b0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            occ_reg         <= '0;
            last_mem        <= '0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            pack_reg       <= pack_next;
            count_reg      <= count_next;
            words_reg      <= words_next;
            tagged_reg     <= tagged_next;
            done_d_reg     <= Image_Done;
            frame_done_reg <= close;
            if (close)
                frame_count_reg <= count_reg;
            if (push_req)
                pushed_ok_reg <= push_ok;
            if (push_req && !push_ok)
                overflow_reg <= 1'b1;
            if (push_ok) begin
                wr_ptr_reg           <= wr_ptr_reg + PTR_W'(1);
                last_mem[wr_ptr_reg] <= push_last;
            end
            if (mark_last)
                last_mem[newest_ptr] <= 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   occ_reg <= occ_reg + (PTR_W+1)'(1);
                2'b01:   occ_reg <= occ_reg - (PTR_W+1)'(1);
                default: occ_reg <= occ_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            word_mem[wr_ptr_reg] <= push_word;
    end

    assign out_valid   = occ_reg != '0;
    assign out_word    = out_valid ? word_mem[rd_ptr_reg] : '0;
    assign out_last    = out_valid && last_mem[rd_ptr_reg];
    assign frame_count = frame_count_reg;
    assign frame_done  = frame_done_reg;
    assign overflow    = overflow_reg;
endmodule

// File: tb/tb_pixel_collector.sv
// Directed bench for pixel_collector: table of whole frames plus hand-written
// sequences for latency, same-cycle close, held Image_Done, overflow and reset.
module tb_pixel_collector;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        new_pixel = 1'b0;
    logic [7:0]  Pixel_Data = 8'h00;
    logic        Image_Done = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [15:0] out_word;
    logic        out_last;
    logic [19:0] frame_count;
    logic        frame_done;
    logic        overflow;

    pixel_collector #(.Data_Depth(8), .Amba_Word(16), .Fifo_Depth(16), .Cnt_Width(20)) dut (
        .clk(clk), .rst(rst), .new_pixel(new_pixel), .Pixel_Data(Pixel_Data),
        .Image_Done(Image_Done), .out_ready(out_ready), .out_valid(out_valid),
        .out_word(out_word), .out_last(out_last), .frame_count(frame_count),
        .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [16:0] cap[$];   // {last, word} of every accepted transfer
    int fd_cnt = 0;

    always @(negedge clk) begin
        if (out_valid && out_ready) cap.push_back({out_last, out_word});
        if (frame_done) fd_cnt++;
    end

    typedef struct packed {
        logic [7:0]  n;
        logic [31:0] pix;   // pixel i in bits [8i+7:8i]
        logic [7:0]  nw;
        logic [50:0] exp;   // word k as {last, word} in bits [17k+16:17k]
        logic [19:0] fc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [16:0] capq(input int k);
        if (k < cap.size()) return cap[k];
        return 17'bx;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pix(input logic [7:0] d);
        new_pixel  = 1'b1;
        Pixel_Data = d;
        step();
        new_pixel  = 1'b0;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        new_pixel  = 1'b0;
        Image_Done = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_word", 32'(out_word), 32'h0);
        chk("rst_last", 32'(out_last), 32'h0);
        chk("rst_fcount", 32'(frame_count), 32'h0);
        chk("rst_fdone", 32'(frame_done), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        step();
        step();
        rst = 1'b1;
        step();
        cap.delete();
        fd_cnt = 0;
        $display("reset applied");
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{n: 8'd4, pix: 32'h44332211, nw: 8'd3,
                    exp: {17'h10000, 17'h04433, 17'h02211}, fc: 20'd4};
        vecs[1] = '{n: 8'd3, pix: 32'h00C3B2A1, nw: 8'd2,
                    exp: {17'h00000, 17'h100C3, 17'h0B2A1}, fc: 20'd3};
        vecs[2] = '{n: 8'd1, pix: 32'h0000007F, nw: 8'd1,
                    exp: {17'h00000, 17'h00000, 17'h1007F}, fc: 20'd1};
        vecs[3] = '{n: 8'd2, pix: 32'h00000201, nw: 8'd2,
                    exp: {17'h00000, 17'h10000, 17'h00201}, fc: 20'd2};

        #3;
        do_reset();

        // One-cycle latency from the completing pixel to out_valid.
        out_ready = 1'b1;
        pix(8'h11);
        chk("lat_valid_after_p0", 32'(out_valid), 32'h0);
        pix(8'h22);
        chk("lat_valid_w0", 32'(out_valid), 32'h1);
        chk("lat_word_w0", 32'(out_word), 32'h2211);
        chk("lat_last_w0", 32'(out_last), 32'h0);
        pix(8'h33);
        chk("lat_valid_after_p2", 32'(out_valid), 32'h0);
        pix(8'h44);
        chk("lat_valid_w1", 32'(out_valid), 32'h1);
        chk("lat_word_w1", 32'(out_word), 32'h4433);
        $display("latency sequence done");
        do_reset();

        for (int v = 0; v < 4; v++) begin
            vec_t cur;
            cur = vecs[v];
            cap.delete();
            fd_cnt = 0;
            out_ready = 1'b1;
            for (int i = 0; i < int'(cur.n); i++) pix(cur.pix[8*i +: 8]);
            Image_Done = 1'b1;
            idle(3);
            Image_Done = 1'b0;
            idle(4);
            chk($sformatf("vec%0d_nwords", v), 32'(cap.size()), 32'(cur.nw));
            for (int k = 0; k < int'(cur.nw); k++)
                chk($sformatf("vec%0d_word%0d", v, k), 32'(capq(k)), 32'(cur.exp[17*k +: 17]));
            chk($sformatf("vec%0d_fcount", v), 32'(frame_count), 32'(cur.fc));
            chk($sformatf("vec%0d_fdone", v), 32'(fd_cnt), 32'h1);
            $display("vector %0d: %0d pixels, %0d words", v, cur.n, cap.size());
        end

        // Pixel in the same cycle as the Image_Done edge, edge held 10 cycles.
        cap.delete();
        fd_cnt = 0;
        pix(8'h44);
        new_pixel  = 1'b1;
        Pixel_Data = 8'h55;
        Image_Done = 1'b1;
        step();
        new_pixel = 1'b0;
        idle(9);
        Image_Done = 1'b0;
        idle(4);
        chk("same_nwords", 32'(cap.size()), 32'h1);
        chk("same_word", 32'(capq(0)), 32'h15544);
        chk("same_fcount", 32'(frame_count), 32'd2);
        chk("held_fdone", 32'(fd_cnt), 32'h1);
        $display("same-cycle close done");

        // Frame end with no pixels.
        cap.delete();
        fd_cnt = 0;
        Image_Done = 1'b1;
        idle(3);
        Image_Done = 1'b0;
        idle(3);
        chk("empty_nwords", 32'(cap.size()), 32'h0);
        chk("empty_fdone", 32'(fd_cnt), 32'h0);
        chk("empty_fcount", 32'(frame_count), 32'd2);
        $display("empty frame done");

        // Overflow with the sink stalled.
        cap.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            pix(8'(i));
            if (i == 31) begin
                chk("ovf_before", 32'(overflow), 32'h0);
                chk("ovf_head_w16", 32'(out_word), 32'h0100);
            end
            if (i == 33) chk("ovf_after17", 32'(overflow), 32'h1);
        end
        chk("ovf_head_valid", 32'(out_valid), 32'h1);
        chk("ovf_head_stable", 32'(out_word), 32'h0100);
        out_ready = 1'b1;
        idle(20);
        chk("ovf_nwords", 32'(cap.size()), 32'd16);
        for (int k = 0; k < 16; k++) begin
            logic [7:0] lo;
            logic [7:0] hi;
            lo = 8'(2*k);
            hi = 8'(2*k + 1);
            chk($sformatf("ovf_word%0d", k), 32'(capq(k)), 32'({1'b0, hi, lo}));
        end
        chk("ovf_sticky", 32'(overflow), 32'h1);
        $display("overflow sequence: %0d words drained", cap.size());

        // Reset in the middle of a frame.
        pix(8'h99);
        do_reset();
        out_ready = 1'b1;
        pix(8'h01);
        pix(8'h02);
        idle(5);
        chk("midrst_nwords", 32'(cap.size()), 32'h1);
        chk("midrst_word", 32'(capq(0)), 32'h00201);
        chk("midrst_overflow", 32'(overflow), 32'h0);
        chk("midrst_fdone", 32'(fd_cnt), 32'h0);
        chk("midrst_fcount", 32'(frame_count), 32'h0);
        $display("mid-frame reset done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
